// File: rtl/mat_mem_arbiter.sv
// mat_mem_arbiter
// Shares one single-port matrix SRAM between a host loader (read/write, linear
// address) and the determinant engine (read-only, row/col indices). Ownership is
// round-robin with a bounded burst: after MAX_BURST consecutive accesses the owner
// yields if the other requester is waiting. Read data returns one cycle after the
// access and is qualified by the rvalid of the requester that issued it.
//
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   h_req/h_we/h_addr/h_wdata     host request, write enable, linear address, write data
//   h_gnt/h_rvalid/h_rdata        host grant, read-data valid, read data
//   e_req/e_i/e_j                 engine read request, row index, column index
//   e_gnt/e_rvalid/e_rdata        engine grant, read-data valid, read data
//   mem_en/mem_we/mem_addr/...    SRAM side; mem_rdata valid the cycle after a read
//   h_acc_cnt/e_acc_cnt           granted-access counters (only with ARB_STATS_EN)
//
// Configuration macro: ARB_STATS_EN adds saturating 32-bit access counters.
module mat_mem_arbiter #(
    parameter int unsigned DW        = 20,
    parameter int unsigned IW        = 4,
    parameter int unsigned AW        = 2 * IW,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    input  logic          e_req,
    input  logic [IW-1:0] e_i,
    input  logic [IW-1:0] e_j,
    output logic          e_gnt,
    output logic          e_rvalid,
    output logic [DW-1:0] e_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef ARB_STATS_EN
    output logic [31:0]   h_acc_cnt,
    output logic [31:0]   e_acc_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {IDLE, OWN_H, OWN_E} state_t;

    state_t        state;
    logic          last_owner_e;  // 1: engine owned last, so host wins the next tie
    logic [BW-1:0] burst_cnt;
    logic          h_acc;
    logic          e_acc;
    logic          burst_last;

    assign h_gnt      = (state == OWN_H);
    assign e_gnt      = (state == OWN_E);
    assign h_acc      = h_gnt & h_req;
    assign e_acc      = e_gnt & e_req;
    assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_owner_e <= 1'b1;
            burst_cnt    <= '0;
            h_rvalid     <= 1'b0;
            e_rvalid     <= 1'b0;
        end else begin
            // Read tag: the issuer's rvalid fires next cycle even if ownership moves.
            h_rvalid <= h_acc & ~h_we;
            e_rvalid <= e_acc;
            case (state)
                IDLE: begin
                    if (h_req && (!e_req || last_owner_e)) begin
                        state        <= OWN_H;
                        last_owner_e <= 1'b0;
                        burst_cnt    <= '0;
                    end else if (e_req) begin
                        state        <= OWN_E;
                        last_owner_e <= 1'b1;
                        burst_cnt    <= '0;
                    end
                end
                OWN_H: begin
                    if (!h_req) begin
                        burst_cnt <= '0;
                        if (e_req) begin
                            state        <= OWN_E;
                            last_owner_e <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (burst_last) begin
                        // Burst exhausted: yield if engine waits, otherwise restart burst.
                        burst_cnt <= '0;
                        if (e_req) begin
                            state        <= OWN_E;
                            last_owner_e <= 1'b1;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                OWN_E: begin
                    if (!e_req) begin
                        burst_cnt <= '0;
                        if (h_req) begin
                            state        <= OWN_H;
                            last_owner_e <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (burst_last) begin
                        burst_cnt <= '0;
                        if (h_req) begin
                            state        <= OWN_H;
                            last_owner_e <= 1'b0;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (h_acc) begin
            mem_en    = 1'b1;
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (e_acc) begin
            mem_en   = 1'b1;
            mem_addr = AW'({e_i, e_j});
        end
    end

    // Both requesters see the raw SRAM output; only rvalid marks ownership.
    assign h_rdata = mem_rdata;
    assign e_rdata = mem_rdata;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_acc_cnt <= '0;
            e_acc_cnt <= '0;
        end else begin
            if (h_acc && (h_acc_cnt != 32'hFFFF_FFFF)) h_acc_cnt <= h_acc_cnt + 32'd1;
            if (e_acc && (e_acc_cnt != 32'hFFFF_FFFF)) e_acc_cnt <= e_acc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Self-checking bench for mat_mem_arbiter: SRAM model, shadow-memory scoreboard,
// arbitration properties and directed scenarios, then randomized traffic.
module tb_mat_mem_arbiter;
    localparam int DW = 20;
    localparam int IW = 4;
    localparam int AW = 8;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          h_req, h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt, h_rvalid;
    logic [DW-1:0] h_rdata;
    logic          e_req;
    logic [IW-1:0] e_i, e_j;
    logic          e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0]   h_acc_cnt, e_acc_cnt;
`endif

    mat_mem_arbiter #(.DW(DW), .IW(IW), .AW(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_i(e_i), .e_j(e_j),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_STATS_EN
        .h_acc_cnt(h_acc_cnt), .e_acc_cnt(e_acc_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model and the bench's own view of what memory should contain.
    logic [DW-1:0] sram   [256];
    logic [DW-1:0] shadow [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues of expected read data per requester.
    logic [DW-1:0] hq[$];
    logic [DW-1:0] eq[$];
    logic          h_acc_s = 1'b0, e_acc_s = 1'b0;
    logic          prev_valid = 1'b0, prev_h = 1'b0, prev_e = 1'b0;
    int            h_wait = 0, e_wait = 0;
    int            n_hrv = 0, n_erv = 0;
    logic [DW-1:0] last_erd = '0;

    // Monitor: checks returned data, then records this cycle's access.
    always @(negedge clk) begin
        if (reset) begin
            hq.delete();
            eq.delete();
            prev_valid = 1'b0;
            h_wait = 0;
            e_wait = 0;
            h_acc_s = 1'b0;
            e_acc_s = 1'b0;
        end else begin
            if (h_rvalid) begin
                n_hrv++;
                if (hq.size() == 0) check("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
                else check("h_rdata", 32'(h_rdata), 32'(hq.pop_front()));
            end else if (hq.size() != 0) begin
                check("h_rvalid_missing", 32'(h_rvalid), 32'd1);
                hq.delete();
            end
            if (e_rvalid) begin
                n_erv++;
                last_erd = e_rdata;
                if (eq.size() == 0) check("e_rvalid_unexpected", 32'(e_rvalid), 32'd0);
                else check("e_rdata", 32'(e_rdata), 32'(eq.pop_front()));
            end else if (eq.size() != 0) begin
                check("e_rvalid_missing", 32'(e_rvalid), 32'd1);
                eq.delete();
            end

            check("gnt_mutex", 32'(h_gnt & e_gnt), 32'd0);
            // Someone requested last cycle <=> someone owns memory now.
            if (prev_valid) check("gnt_follows_req", 32'(h_gnt | e_gnt), 32'(prev_h | prev_e));
            if (prev_valid && prev_h && !prev_e) check("h_sole_gnt", 32'(h_gnt), 32'd1);
            if (prev_valid && prev_e && !prev_h) check("e_sole_gnt", 32'(e_gnt), 32'd1);

            if (h_req && !h_gnt) h_wait++; else h_wait = 0;
            if (e_req && !e_gnt) e_wait++; else e_wait = 0;
            if (h_wait > MB + 1) begin
                check("h_wait_bound", 32'(h_wait), 32'(MB + 1));
                h_wait = 0;
            end
            if (e_wait > MB + 1) begin
                check("e_wait_bound", 32'(e_wait), 32'(MB + 1));
                e_wait = 0;
            end

            h_acc_s = h_req & h_gnt;
            e_acc_s = e_req & e_gnt;
            if (h_acc_s) begin
                check("mem_h", {mem_en, mem_we, 2'b0, mem_wdata, mem_addr},
                      {1'b1, h_we, 2'b0, h_wdata, h_addr});
                if (h_we) shadow[h_addr] = h_wdata;
                else      hq.push_back(shadow[h_addr]);
            end else if (e_acc_s) begin
                check("mem_e", {mem_en, mem_we, 2'b0, mem_wdata, mem_addr},
                      {1'b1, 1'b0, 2'b0, 20'd0, e_i, e_j});
                eq.push_back(shadow[{e_i, e_j}]);
            end else begin
                check("mem_idle", {mem_en, mem_we, 2'b0, mem_wdata, mem_addr}, 32'd0);
            end
            prev_h = h_req;
            prev_e = e_req;
            prev_valid = 1'b1;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        h_req = 0; e_req = 0; h_we = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    // Hold h_req until n host accesses have been made, then drop it.
    task automatic hold_h(input int n, input string name);
        int got = 0;
        h_req = 1;
        for (int c = 0; c < 60 && got < n; c++) begin
            @(negedge clk);
            if (h_req && h_gnt) got++;
        end
        if (got < n) check({name, "_timeout"}, 32'(got), 32'(n));
        @(posedge clk); #1;
        h_req = 0;
    endtask

    task automatic hold_e(input int n, input string name);
        int got = 0;
        e_req = 1;
        for (int c = 0; c < 60 && got < n; c++) begin
            @(negedge clk);
            if (e_req && e_gnt) got++;
        end
        if (got < n) check({name, "_timeout"}, 32'(got), 32'(n));
        @(posedge clk); #1;
        e_req = 0;
    endtask

    task automatic host_agent(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (!h_req || h_acc_s) begin
                h_req   = ($urandom_range(0, 3) != 0);
                h_we    = $urandom_range(0, 1) == 1;
                h_addr  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
                h_wdata = 20'($urandom);
            end
        end
        @(posedge clk); #1;
        h_req = 0;
    endtask

    task automatic eng_agent(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (!e_req || e_acc_s) begin
                e_req = ($urandom_range(0, 2) != 0);
                e_i   = 4'($urandom_range(0, 3));
                e_j   = 4'($urandom_range(0, 3));
            end
        end
        @(posedge clk); #1;
        e_req = 0;
    endtask

    initial begin
        int first_h, first_e, h_before_e, cnt, hrv0, erv0;
        for (int a = 0; a < 256; a++) begin
            sram[a]   = 20'(a * 37);
            shadow[a] = 20'(a * 37);
        end
        reset = 1; h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        e_req = 0; e_i = '0; e_j = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_state", {h_gnt, e_gnt, mem_en, mem_we, h_rvalid, e_rvalid}, 32'd0);

        // Reset asserted while a host read is in flight.
        h_we = 0; h_addr = 8'h21; h_req = 1;
        cnt = 0;
        for (int c = 0; c < 10 && !(h_req && h_gnt); c++) @(negedge clk);
        check("t1_granted", 32'(h_gnt), 32'd1);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        check("t1_after_reset", {h_rvalid, e_rvalid, h_gnt, e_gnt, mem_en}, 32'd0);
        h_req = 0;
        @(posedge clk); #1;
        reset = 0;

        // Host write then engine read of the same element.
        do_reset();
        hrv0 = n_hrv; erv0 = n_erv;
        h_we = 1; h_addr = 8'h12; h_wdata = 20'd7;
        hold_h(1, "t2_write");
        e_i = 4'd1; e_j = 4'd2;
        hold_e(1, "t2_read");
        repeat (3) @(negedge clk);
        check("t2_e_rvalid_count", 32'(n_erv - erv0), 32'd1);
        check("t2_e_rdata", 32'(last_erd), 32'd7);
        check("t2_h_rvalid_count", 32'(n_hrv - hrv0), 32'd0);

        // Simultaneous requests from reset: host first, 8-access burst, then engine.
        // Host reads so its last read returns while the engine owns memory.
        do_reset();
        h_we = 0; h_addr = 8'h33; e_i = 4'd3; e_j = 4'd1;
        h_req = 1; e_req = 1;
        first_h = -1; first_e = -1; h_before_e = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (h_gnt && first_h < 0) first_h = k;
            if (e_gnt && first_e < 0) first_e = k;
            if (h_gnt && h_req && first_e < 0) h_before_e++;
            if (k == first_e) check("t5_h_rvalid_on_switch", {h_rvalid, e_rvalid}, 32'b10);
        end
        check("t3_first_h", 32'(first_h), 32'd1);
        check("t3_host_burst", 32'(h_before_e), 32'(MB));
        check("t3_first_e", 32'(first_e), 32'(MB + 1));
        @(posedge clk); #1;
        h_req = 0; e_req = 0;
        repeat (2) @(posedge clk);

        // Engine alone for 20 cycles: continuous grant through burst wrap.
        do_reset();
        e_i = 4'd2; e_j = 4'd2; e_req = 1;
        erv0 = n_erv;
        cnt = 0;
        @(negedge clk);
        check("t4_idle_first", 32'(e_gnt), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (e_gnt && e_req && !h_gnt) cnt++;
        end
        check("t4_engine_reads", 32'(cnt), 32'd20);
        @(posedge clk); #1;
        e_req = 0;
        repeat (3) @(negedge clk);
        check("t4_rvalid_count", 32'(n_erv - erv0), 32'd20);

`ifdef ARB_STATS_EN
        do_reset();
        h_we = 1; h_addr = 8'h05; h_wdata = 20'h1234;
        hold_h(5, "t6_host");
        e_i = 4'd0; e_j = 4'd5;
        hold_e(3, "t6_eng");
        repeat (2) @(negedge clk);
        check("t6_h_acc_cnt", h_acc_cnt, 32'd5);
        check("t6_e_acc_cnt", e_acc_cnt, 32'd3);
`endif

        // Randomized contention.
        do_reset();
        fork
            host_agent(3000);
            eng_agent(3000);
        join
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
